// File: rtl/shared_mem_arbiter_pkg.sv
// shared_mem_arbiter_pkg: shared types for the shared-memory arbiter.
//   state_t : arbiter FSM states (S_IDLE, S_ACCESS, S_DONE)
//   op_t    : latched operation of the granted request (OP_RD, OP_WR)
package shared_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage

// File: rtl/shared_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   i_req   in  N   request vector
//   i_ptr   in  PW  highest-priority index this round
//   o_gnt   out N   one-hot grant: first requester at or after i_ptr (mod N)
//   o_valid out 1   at least one request present
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic          o_valid
);

   assign o_valid = |i_req;

   // Walk the ring from farthest to nearest so the nearest requester
   // overwrites any earlier hit and no found-flag is needed.
   always_comb begin
      o_gnt = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % N]) o_gnt = N'(1) << ((int'(i_ptr) + k) % N);
      end
   end

endmodule

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter sharing one single-port data memory
// among NCORES cores; one access at a time, waiting cores are stalled.
//   clk, reset            clock (rising edge), async active-high reset
//   core_sel/rd/wr        per-core select and strobes (rd+wr counts as write)
//   core_addr/core_wdata  packed per-core address / write data
//   core_stall            combinational: request pending and not done
//   core_done             registered one-cycle pulse to the owner
//   core_rdata            registered read data, valid with core_done
//   mem_addr/wdata/rd/wr  registered memory port
//   mem_rdata             memory read data, captured entering DONE
//   busy                  registered, arbiter not IDLE
module shared_mem_arbiter
   import shared_mem_arbiter_pkg::*;
#(
   parameter int NCORES = 4,
   parameter int AW     = 32,
   parameter int DW     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCORES-1:0]    core_sel,
   input  logic [NCORES-1:0]    core_rd,
   input  logic [NCORES-1:0]    core_wr,
   input  logic [NCORES*AW-1:0] core_addr,
   input  logic [NCORES*DW-1:0] core_wdata,
   output logic [NCORES-1:0]    core_stall,
   output logic [NCORES-1:0]    core_done,
   output logic [DW-1:0]        core_rdata,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_wdata,
   output logic                 mem_rd,
   output logic                 mem_wr,
   input  logic [DW-1:0]        mem_rdata,
   output logic                 busy
);

   localparam int PW = $clog2(NCORES);

   state_t            r_state, w_state_nx;
   op_t               r_op, w_gnt_op;
   logic [PW-1:0]     r_ptr, r_owner, w_gnt_idx;
   logic [NCORES-1:0] w_req, w_gnt, r_done, w_done_nx;
   logic              w_valid, w_latch;
   logic [AW-1:0]     r_addr, w_gnt_addr;
   logic [DW-1:0]     r_wdata, w_gnt_wdata, r_rdata;
   logic              r_mem_rd, r_mem_wr, r_busy;

   assign w_req      = core_sel & (core_rd | core_wr);
   assign core_stall = w_req & ~r_done;

   rr_pick #(.N(NCORES), .PW(PW)) u_pick (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_valid (w_valid)
   );

   // Mux the granted core's request fields out of the packed buses.
   always_comb begin
      w_gnt_idx   = '0;
      w_gnt_op    = OP_RD;
      w_gnt_addr  = '0;
      w_gnt_wdata = '0;
      for (int i = 0; i < NCORES; i++) begin
         if (w_gnt[i]) begin
            w_gnt_idx   = PW'(i);
            w_gnt_op    = op_t'(core_wr[i]);
            w_gnt_addr  = core_addr[i*AW +: AW];
            w_gnt_wdata = core_wdata[i*DW +: DW];
         end
      end
   end

   // Requests are only sampled in IDLE, so a non-owner never slips in mid-transaction.
   always_comb begin
      w_state_nx = r_state;
      w_latch    = 1'b0;
      w_done_nx  = '0;
      case (r_state)
         S_IDLE: begin
            w_latch    = w_valid;
            w_state_nx = w_valid ? S_ACCESS : S_IDLE;
         end
         S_ACCESS: begin
            w_state_nx         = S_DONE;
            w_done_nx[r_owner] = 1'b1;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_owner  <= '0;
         r_op     <= OP_RD;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_mem_rd <= 1'b0;
         r_mem_wr <= 1'b0;
         r_done   <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_busy   <= (w_state_nx != S_IDLE);
         r_mem_rd <= w_latch & (w_gnt_op == OP_RD);
         r_mem_wr <= w_latch & (w_gnt_op == OP_WR);
         r_done   <= w_done_nx;
         if (w_latch) begin
            r_owner <= w_gnt_idx;
            r_op    <= w_gnt_op;
            r_addr  <= w_gnt_addr;
            r_wdata <= w_gnt_wdata;
         end
         // Memory answers during ACCESS; the capture lines up with the done pulse.
         if (r_state == S_ACCESS && r_op == OP_RD) r_rdata <= mem_rdata;
         if (r_state == S_DONE) r_ptr <= (r_owner == PW'(NCORES - 1)) ? '0 : r_owner + 1'b1;
      end
   end

   assign core_done  = r_done;
   assign core_rdata = r_rdata;
   assign mem_addr   = r_addr;
   assign mem_wdata  = r_wdata;
   assign mem_rd     = r_mem_rd;
   assign mem_wr     = r_mem_wr;
   assign busy       = r_busy;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: scoreboard bench for shared_mem_arbiter.
module tb_shared_mem_arbiter;
   localparam int N = 4, AW = 32, DW = 32;

   logic clk = 1'b0, reset = 1'b1;
   logic [N-1:0]    core_sel = '0, core_rd = '0, core_wr = '0;
   logic [N*AW-1:0] core_addr = '0;
   logic [N*DW-1:0] core_wdata = '0;
   logic [N-1:0]    core_stall, core_done;
   logic [DW-1:0]   core_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0]   mem_addr;
   logic            mem_rd, mem_wr, busy;

   shared_mem_arbiter #(.NCORES(N), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .core_sel(core_sel), .core_rd(core_rd), .core_wr(core_wr),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_stall(core_stall), .core_done(core_done), .core_rdata(core_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory model: data only while mem_rd, garbage otherwise to expose mistimed capture.
   always_comb mem_rdata = !mem_rd ? 32'hBAD0BAD0 :
                           (mem_addr == 32'h80) ? 32'hDEADBEEF : {mem_addr[15:0], ~mem_addr[15:0]};

   typedef struct { int core; logic [31:0] rdata; } done_t;
   typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; } acc_t;
   done_t dq[$];
   acc_t  aq[$];
   int n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req_on(input int c, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
      core_sel[c] = 1'b1;
      core_rd[c]  = rd;
      core_wr[c]  = wr;
      core_addr[c*AW +: AW]  = a;
      core_wdata[c*DW +: DW] = d;
   endtask

   task automatic req_off(input int c);
      core_sel[c] = 1'b0;
      core_rd[c]  = 1'b0;
      core_wr[c]  = 1'b0;
   endtask

   task automatic push_acc(input bit wr, input logic [31:0] a, input logic [31:0] d);
      acc_t x;
      x.wr = wr; x.addr = a; x.wdata = d;
      aq.push_back(x);
   endtask

   task automatic push_done(input int c, input logic [31:0] rd);
      done_t x;
      x.core = c; x.rdata = rd;
      dq.push_back(x);
   endtask

   // Wait for core c's done pulse, reporting the number of negedges observed.
   task automatic wait_done(input int c, input bit drop, output int n);
      bit found = 0;
      n = 0;
      while (!found && n < 20) begin
         @(negedge clk);
         n++;
         if (core_done[c]) found = 1;
      end
      if (!found) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_done core%0d: no done within %0d cycles", c, n);
      end
      if (drop) begin
         tick();
         req_off(c);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      acc_t  a;
      done_t d;
      if (!reset) begin
         if (mem_rd || mem_wr) begin
            if (aq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL mem_unexpected: rd=%b wr=%b addr=0x%0h", mem_rd, mem_wr, mem_addr);
            end else begin
               a = aq.pop_front();
               chk("mem_op", {30'd0, mem_wr, mem_rd}, {30'd0, a.wr, ~a.wr});
               chk("mem_addr", mem_addr, a.addr);
               if (a.wr) chk("mem_wdata", mem_wdata, a.wdata);
            end
         end
         if (|core_done) begin
            if (dq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL done_unexpected: core_done=0x%0h", core_done);
            end else begin
               d = dq.pop_front();
               chk("done_vec", 32'(core_done), 32'd1 << d.core);
               chk("core_rdata", core_rdata, d.rdata);
               chk("stall_at_done", 32'(core_stall), 32'(core_sel & (core_rd | core_wr) & ~core_done));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_strobes", {29'd0, mem_rd, mem_wr, busy}, 32'd0);
      chk("rst_done", 32'(core_done), 32'd0);
      chk("rst_rdata", core_rdata, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      reset = 1'b0;

      // 1: single read by core1
      req_on(1, 1, 0, 32'h80, 32'h0);
      push_acc(0, 32'h80, 32'h0);
      push_done(1, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_c0_stall", 32'(core_stall), 32'h2);
      chk("t1_c0_mem_rd", 32'(mem_rd), 32'd0);
      chk("t1_c0_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t1_c1_mem_rd", 32'(mem_rd), 32'd1);
      chk("t1_c1_stall", 32'(core_stall), 32'h2);
      chk("t1_c1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t1_c2_done", 32'(core_done), 32'h2);
      chk("t1_c2_rdata", core_rdata, 32'hDEADBEEF);
      chk("t1_c2_stall", 32'(core_stall), 32'h0);
      chk("t1_c2_mem_rd", 32'(mem_rd), 32'd0);
      tick();
      req_off(1);
      @(negedge clk);
      chk("t1_c3_busy", 32'(busy), 32'd0);
      chk("t1_c3_done", 32'(core_done), 32'd0);

      // 2: write by core2
      tick();
      req_on(2, 0, 1, 32'h100, 32'h1234);
      push_acc(1, 32'h100, 32'h1234);
      push_done(2, 32'hDEADBEEF);
      @(negedge clk);
      @(negedge clk);
      chk("t2_c1_mem_wr", 32'(mem_wr), 32'd1);
      chk("t2_c1_addr", mem_addr, 32'h100);
      chk("t2_c1_wdata", mem_wdata, 32'h1234);
      @(negedge clk);
      chk("t2_c2_done", 32'(core_done), 32'h4);
      tick();
      req_off(2);

      // 3: all four cores request from reset
      do_reset();
      req_on(0, 1, 0, 32'h200, 32'h0);
      req_on(1, 0, 1, 32'h204, 32'h1111);
      req_on(2, 1, 0, 32'h208, 32'h0);
      req_on(3, 0, 1, 32'h20C, 32'h3333);
      push_acc(0, 32'h200, 0); push_done(0, 32'h0200FDFF);
      push_acc(1, 32'h204, 32'h1111); push_done(1, 32'h0200FDFF);
      push_acc(0, 32'h208, 0); push_done(2, 32'h0208FDF7);
      push_acc(1, 32'h20C, 32'h3333); push_done(3, 32'h0208FDF7);
      for (int c = 0; c < N; c++) begin
         wait_done(c, 1, n);
         chk($sformatf("t3_spacing_core%0d", c), n, 3);
      end

      // 4: core0 continuous, core3 once (rr_ptr is 0 here)
      tick();
      req_on(0, 1, 0, 32'h10, 32'h0);
      req_on(3, 1, 0, 32'h30, 32'h0);
      push_acc(0, 32'h10, 0); push_done(0, 32'h0010FFEF);
      push_acc(0, 32'h30, 0); push_done(3, 32'h0030FFCF);
      push_acc(0, 32'h10, 0); push_done(0, 32'h0010FFEF);
      wait_done(0, 0, n);
      wait_done(3, 1, n);
      chk("t4_core3_second_grant", n, 3);
      wait_done(0, 1, n);
      chk("t4_core0_third_grant", n, 3);

      // 6: rd+wr together is a write; rdata holds
      tick();
      req_on(0, 1, 1, 32'h40, 32'hCAFE);
      push_acc(1, 32'h40, 32'hCAFE);
      push_done(0, 32'h0010FFEF);
      wait_done(0, 1, n);

      // 5: reset asserted during ACCESS (rr_ptr is 1 before reset)
      tick();
      req_on(2, 1, 0, 32'h50, 32'h0);
      push_acc(0, 32'h50, 0);
      @(negedge clk);
      @(negedge clk);
      chk("t5_in_access", 32'(mem_rd), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("t5_rst_strobes", {29'd0, mem_rd, mem_wr, busy}, 32'd0);
      chk("t5_rst_done", 32'(core_done), 32'd0);
      chk("t5_rst_rdata", core_rdata, 32'd0);
      chk("t5_rst_addr", mem_addr, 32'd0);
      chk("t5_rst_wdata", mem_wdata, 32'd0);
      req_off(2);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_no_done", 32'(core_done), 32'd0);
      end
      tick();
      req_on(0, 1, 0, 32'h60, 32'h0);
      req_on(3, 1, 0, 32'h70, 32'h0);
      push_acc(0, 32'h60, 0); push_done(0, 32'h0060FF9F);
      push_acc(0, 32'h70, 0); push_done(3, 32'h0070FF8F);
      wait_done(0, 1, n);
      chk("t5_ptr0_first", n, 3);
      wait_done(3, 1, n);

      repeat (3) @(negedge clk);
      chk("done_queue_empty", dq.size(), 0);
      chk("mem_queue_empty", aq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
